cronometru_bcd: RTL and testbench
=================================

Name: cronometru_bcd

Overview:
- Minute/second stopwatch built from four cascaded BCD digit counters. It displays MM:SS, counting 00:00 to 59:59.
- A `pause` input freezes counting. A one-cycle `carry` pulse marks each wrap from 59:59 to 00:00.
- An internal prescaler divides the system clock down to the count tick. It sits between the clock domain and a 7-segment display driver.

Parameters:
- TICK_DIV, default 1: number of enabled clock cycles per count tick. Legal range 1 to 2^26. A value of 1 means count on every enabled clock edge.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Low clears all state immediately.
- pause  input  1  level-sensitive hold. 1 freezes the counters and prescaler; 0 counts.
- BCD0  output  4  seconds units, 0-9.
- BCD1  output  4  seconds tens, 0-5.
- BCD2  output  4  minutes units, 0-9.
- BCD3  output  4  minutes tens, 0-5.
- carry  output  1  one-cycle pulse on a 59:59 to 00:00 wrap.

Behaviour:
- Reset:
  - The block has one clock and an asynchronous, active-low reset.
  - While reset is low, BCD0-3 = 0, carry = 0 and the prescaler = 0, independent of clk.
  - Release is sampled at the next rising edge. The first possible increment is on the first rising edge with reset high and pause low, when TICK_DIV = 1.
- Enable: en = (pause == 0). When en = 0, all registers hold and carry = 0.
- Prescaler:
  - Counter runs 0 to TICK_DIV-1, advancing by 1 on each enabled edge.
  - tick is high on the enabled edge where the prescaler equals TICK_DIV-1; the prescaler then returns to 0.
  - With TICK_DIV = 1 the prescaler is absent and tick = en.
- Digit cascade on tick. Each digit increments only when all lower digits are at their max:
  - BCD0: 0-9; wraps 9 to 0 and generates c0.
  - BCD1: increments on c0; 0-5; wraps 5 to 0 and generates c1.
  - BCD2: increments on c1; 0-9; wraps 9 to 0 and generates c2.
  - BCD3: increments on c2; 0-5; wraps 5 to 0 and generates the wrap condition.
- carry:
  - Registered output. It is 1 for exactly the clock cycle following the tick edge that takes 59:59 to 00:00; otherwise 0.
  - There is no saturation; counting continues after the wrap.
- All digit outputs are registered. Latency from tick edge to the updated value is 0 cycles, i.e. the value is visible after that edge.
- Illegal BCD values cannot be reached. If one is forced, the next tick loads 0 into that digit.
- Pause toggling mid-prescale keeps the prescaler position; there is no restart.
- A reset assertion mid-count zeroes everything at once, including a pending carry.
- pause and reset together: reset wins.

Test Plan:
- TICK_DIV = 1; hold reset low 2 cycles -> all BCD = 0, carry = 0. Release with pause = 0, then apply 10 edges -> BCD1 = 1, BCD0 = 0.
- From 00:00, apply 60 enabled edges -> BCD2 = 1, BCD1 = 0, BCD0 = 0. Apply 599 more -> 10:59 (BCD3 = 1, BCD2 = 0, BCD1 = 5, BCD0 = 9).
- Count to 59:59 (3599 edges), then 1 more -> 00:00. carry = 1 for exactly one cycle, then 0 thereafter.
- At 00:07, hold pause = 1 for 5 cycles -> stays 00:07, carry = 0. Release pause, 1 edge -> 00:08.
- Toggle pause every 5 clocks from reset for 100 clocks -> total count = number of edges with pause low (50 -> 00:50).
- TICK_DIV = 4: 8 enabled edges -> BCD0 = 2. Assert reset low asynchronously between edges -> outputs 0 before the next edge.

Source files
------------

// File: rtl/cronometru_bcd.sv
// MM:SS stopwatch: four cascaded BCD digit counters driven by a prescaled tick.
// The carry output pulses for one cycle on each 59:59 -> 00:00 wrap.
module cronometru_bcd #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  output logic [3:0] BCD0,
  output logic [3:0] BCD1,
  output logic [3:0] BCD2,
  output logic [3:0] BCD3,
  output logic       carry
);

  logic en;
  logic tick;

  assign en = ~pause;

  generate
    if (TICK_DIV == 1) begin : g_nodiv
      assign tick = en;
    end else begin : g_div
      localparam int PW = $clog2(TICK_DIV);
      localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
      logic [PW-1:0] presc;

      // Prescaler only advances while enabled, so a pause keeps its position.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          presc <= '0;
        end else if (en) begin
          presc <= (presc == LAST) ? '0 : presc + PW'(1);
        end
      end

      assign tick = en && (presc == LAST);
    end
  endgenerate

  logic max0, max1, max2, max3;
  logic wrap;

  assign max0 = (BCD0 == 4'd9);
  assign max1 = (BCD1 == 4'd5);
  assign max2 = (BCD2 == 4'd9);
  assign max3 = (BCD3 == 4'd5);
  assign wrap = tick && max0 && max1 && max2 && max3;

  // An out-of-range digit is forced back to zero on the next tick.
  function automatic logic [3:0] nextDigit(input logic [3:0] d,
                                           input logic [3:0] maxV,
                                           input logic inc);
    logic [3:0] r;
    r = d;
    if (d > maxV) begin
      r = 4'd0;
    end else if (inc) begin
      r = (d == maxV) ? 4'd0 : d + 4'd1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      BCD0  <= 4'd0;
      BCD1  <= 4'd0;
      BCD2  <= 4'd0;
      BCD3  <= 4'd0;
      carry <= 1'b0;
    end else begin
      carry <= wrap;
      if (tick) begin
        BCD0 <= nextDigit(BCD0, 4'd9, 1'b1);
        BCD1 <= nextDigit(BCD1, 4'd5, max0);
        BCD2 <= nextDigit(BCD2, 4'd9, max0 && max1);
        BCD3 <= nextDigit(BCD3, 4'd5, max0 && max1 && max2);
      end
    end
  end

endmodule

// File: tb/tb_cronometru_bcd.sv
// Bench for cronometru_bcd: two instances (TICK_DIV 1 and 4) checked against
// an arithmetic model counting enabled edges and converting to MM:SS.
module tb_cronometru_bcd;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] a0, a1, a2, a3;
  logic [3:0] b0, b1, b2, b3;
  logic       aCarry, bCarry;

  longint edgesA, edgesB;
  logic   expCarryA, expCarryB;
  int     nAssert = 0;
  int     nFail = 0;

  cronometru_bcd #(.TICK_DIV(1)) dutA (
    .clk(clk), .reset(reset), .pause(pause),
    .BCD0(a0), .BCD1(a1), .BCD2(a2), .BCD3(a3), .carry(aCarry)
  );

  cronometru_bcd #(.TICK_DIV(4)) dutB (
    .clk(clk), .reset(reset), .pause(pause),
    .BCD0(b0), .BCD1(b1), .BCD2(b2), .BCD3(b3), .carry(bCarry)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkDut(input string name, input longint edges, input int div,
                          input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic [3:0] d3,
                          input logic c, input logic expC);
    int s;
    s = int'((edges / div) % 3600);
    checkValue({name, ".BCD0"}, d0, 4'(s % 10));
    checkValue({name, ".BCD1"}, d1, 4'((s / 10) % 6));
    checkValue({name, ".BCD2"}, d2, 4'((s / 60) % 10));
    checkValue({name, ".BCD3"}, d3, 4'(s / 600));
    checkValue({name, ".carry"}, {3'b000, c}, {3'b000, expC});
  endtask

  task automatic checkOutput(input string tag);
    checkDut({tag, "/div1"}, edgesA, 1, a0, a1, a2, a3, aCarry, expCarryA);
    checkDut({tag, "/div4"}, edgesB, 4, b0, b1, b2, b3, bCarry, expCarryB);
  endtask

  // Model: seconds = floor(enabled edges / TICK_DIV) mod 3600; carry after a tick landing on 0.
  task automatic modelEdge();
    if (!reset) begin
      edgesA = 0; edgesB = 0;
      expCarryA = 1'b0; expCarryB = 1'b0;
    end else if (!pause) begin
      edgesA++;
      edgesB++;
      expCarryA = (edgesA % 3600 == 0);
      expCarryB = (edgesB % 4 == 0) && ((edgesB / 4) % 3600 == 0);
    end else begin
      expCarryA = 1'b0;
      expCarryB = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic p, input string tag);
    pause = p;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput(tag);
  endtask

  // Called at a falling edge: drops reset between edges, checks, then releases at the next falling edge.
  task automatic asyncReset(input string tag);
    #2 reset = 1'b0;
    edgesA = 0; edgesB = 0;
    expCarryA = 1'b0; expCarryB = 1'b0;
    #1 checkOutput(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    edgesA = 0; edgesB = 0;
    expCarryA = 1'b0; expCarryB = 1'b0;

    $display("[TB] reset and first ten seconds");
    repeat (2) @(negedge clk);
    checkOutput("hold_reset");
    reset = 1'b1;
    repeat (10) applyStimulus(1'b0, "count10");
    checkValue("at10.BCD1", a1, 4'd1);
    checkValue("at10.BCD0", a0, 4'd0);

    $display("[TB] minute rollover and 10:59");
    repeat (50) applyStimulus(1'b0, "count60");
    checkValue("at60.BCD2", a2, 4'd1);
    checkValue("at60.BCD1", a1, 4'd0);
    repeat (599) applyStimulus(1'b0, "count659");
    checkValue("at659.BCD3", a3, 4'd1);
    checkValue("at659.BCD2", a2, 4'd0);
    checkValue("at659.BCD1", a1, 4'd5);
    checkValue("at659.BCD0", a0, 4'd9);

    $display("[TB] wrap at 59:59");
    repeat (2940) applyStimulus(1'b0, "count3599");
    checkValue("at3599.BCD3", a3, 4'd5);
    checkValue("at3599.BCD0", a0, 4'd9);
    applyStimulus(1'b0, "wrap");
    checkValue("wrap.carry", {3'b000, aCarry}, 4'd1);
    checkValue("wrap.BCD3", a3, 4'd0);
    repeat (3) applyStimulus(1'b0, "after_wrap");
    checkValue("after_wrap.carry", {3'b000, aCarry}, 4'd0);

    $display("[TB] pause hold at 00:07");
    asyncReset("rst_pause");
    repeat (7) applyStimulus(1'b0, "to7");
    repeat (5) applyStimulus(1'b1, "paused");
    checkValue("paused.BCD0", a0, 4'd7);
    applyStimulus(1'b0, "resume");
    checkValue("resume.BCD0", a0, 4'd8);

    $display("[TB] pause toggling every 5 clocks");
    asyncReset("rst_toggle");
    for (int i = 0; i < 100; i++) applyStimulus(((i / 5) % 2) == 1, "toggle");
    checkValue("toggle.BCD1", a1, 4'd5);
    checkValue("toggle.BCD0", a0, 4'd0);

    $display("[TB] TICK_DIV=4 and asynchronous reset between edges");
    asyncReset("rst_div4");
    repeat (8) applyStimulus(1'b0, "div4");
    checkValue("div4.BCD0", b0, 4'd2);
    asyncReset("async_mid");

    $display("[TB] random pause with sporadic resets");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 4) == 0, "random");
      if ($urandom_range(0, 299) == 0) asyncReset("random_rst");
    end

    $display("[TB] reset clears pending carry");
    asyncReset("rst_pending");
    repeat (3600) applyStimulus(1'b0, "to_wrap");
    checkValue("pending.carry", {3'b000, aCarry}, 4'd1);
    asyncReset("pending_cleared");
    checkValue("pending_cleared.carry", {3'b000, aCarry}, 4'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
